// File: rtl/mac_row_ctrl.sv
// Sequencer for a row of MAC tiles: issues kernel-load then execute instructions
// from the L0 buffer and skews them down the rows as a diagonal wavefront.
module mac_row_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int cnt_bw = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [cnt_bw-1:0]   kernel_cycles,
  input  logic [cnt_bw-1:0]   exec_cycles,
  input  logic                l0_empty,
  output logic                l0_rd,
  output logic [2*row-1:0]    inst_w,
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] GAP   = 3'd2;
  localparam logic [2:0] EXEC  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam int DRAIN_LEN = row + col - 1;
  localparam int DW        = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN - 1);

  logic [2:0]        state_reg, state_next;
  logic [cnt_bw-1:0] cnt_reg, cnt_next;
  logic [cnt_bw-1:0] k_reg, k_next;
  logic [cnt_bw-1:0] e_reg, e_next;
  logic [DW-1:0]     drain_reg, drain_next;
  logic              issue;
  logic [1:0]        issue_inst;
  logic [cnt_bw:0]   cnt_inc;

  // Counts are taken on start so a pass is immune to mid-pass input changes.
  assign issue   = ((state_reg == LOAD) || (state_reg == EXEC)) && !l0_empty;
  assign cnt_inc = {1'b0, cnt_reg} + {{cnt_bw{1'b0}}, 1'b1};
  assign l0_rd   = issue;
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);

  always_comb begin
    issue_inst = 2'b00;
    if (issue) begin
      issue_inst = (state_reg == LOAD) ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    k_next     = k_reg;
    e_next     = e_reg;
    drain_next = drain_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          k_next     = kernel_cycles;
          e_next     = exec_cycles;
          cnt_next   = '0;
          state_next = (kernel_cycles == '0) ? GAP : LOAD;
        end
      end
      LOAD: begin
        if (issue) begin
          if (cnt_inc == {1'b0, k_reg}) begin
            cnt_next   = '0;
            state_next = GAP;
          end else begin
            cnt_next = cnt_inc[cnt_bw-1:0];
          end
        end
      end
      GAP: begin
        cnt_next   = '0;
        drain_next = '0;
        state_next = (e_reg == '0) ? DRAIN : EXEC;
      end
      EXEC: begin
        if (issue) begin
          if (cnt_inc == {1'b0, e_reg}) begin
            cnt_next   = '0;
            drain_next = '0;
            state_next = DRAIN;
          end else begin
            cnt_next = cnt_inc[cnt_bw-1:0];
          end
        end
      end
      DRAIN: begin
        if (drain_reg == DRAIN_LAST) begin
          state_next = DONE;
        end else begin
          drain_next = drain_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      k_reg     <= '0;
      e_reg     <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      k_reg     <= k_next;
      e_reg     <= e_next;
      drain_reg <= drain_next;
    end
  end

  // Row 0 is aligned with L0 read data; each further row lags by one stage.
  logic [1:0] inst_reg [row];

  genvar gi;
  generate
    for (gi = 0; gi < row; gi++) begin : g_row
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          inst_reg[gi] <= 2'b00;
        end else if (gi == 0) begin
          inst_reg[gi] <= issue_inst;
        end else begin
          inst_reg[gi] <= inst_reg[(gi > 0) ? gi - 1 : 0];
        end
      end
      assign inst_w[2*gi +: 2] = inst_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_mac_row_ctrl.sv
// Directed bench for mac_row_ctrl (row=4, col=4): per-cycle logs are reduced to
// bit masks / counts and compared with hand-derived cycle ranges.
module tb_mac_row_ctrl;
  localparam int ROW = 4;
  localparam int COL = 4;
  localparam int CBW = 8;
  localparam int MAXC = 300;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [CBW-1:0] kernel_cycles = '0;
  logic [CBW-1:0] exec_cycles = '0;
  logic           l0_empty = 1'b0;
  logic           l0_rd;
  logic [2*ROW-1:0] inst_w;
  logic           busy;
  logic           done;

  int checks = 0;
  int failures = 0;
  int illegal = 0;

  logic [31:0] rd_m, busy_m, done_m, r0l_m, r0e_m, r3l_m, r3e_m;
  int rd_cnt, r0l_cnt, r3l_cnt, load_any_cnt, done_cnt, done_cyc;

  mac_row_ctrl #(.row(ROW), .col(COL), .cnt_bw(CBW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .kernel_cycles(kernel_cycles), .exec_cycles(exec_cycles),
    .l0_empty(l0_empty), .l0_rd(l0_rd), .inst_w(inst_w),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Cycle c is the period just before clock edge c; start is driven in cycle 0.
  task automatic run_pass(input int k, input int e, input int st_lo, input int st_hi,
                          input int xs1, input int xs2, input int ncyc);
    rd_m = '0; busy_m = '0; done_m = '0; r0l_m = '0; r0e_m = '0; r3l_m = '0; r3e_m = '0;
    rd_cnt = 0; r0l_cnt = 0; r3l_cnt = 0; load_any_cnt = 0; done_cnt = 0; done_cyc = -1;
    kernel_cycles = CBW'(k);
    exec_cycles   = CBW'(e);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start    = (c == 0) || (c == xs1) || (c == xs2);
      l0_empty = (c >= st_lo) && (c <= st_hi);
      #1;
      if (l0_rd) rd_cnt++;
      if (inst_w[1:0] == 2'b01) r0l_cnt++;
      if (inst_w[7:6] == 2'b01) r3l_cnt++;
      for (int r = 0; r < ROW; r++) begin
        if (inst_w[2*r +: 2] == 2'b11) illegal++;
        if (inst_w[2*r +: 2] == 2'b01) load_any_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c < 32) begin
        rd_m[c]   = l0_rd;
        busy_m[c] = busy;
        done_m[c] = done;
        r0l_m[c]  = (inst_w[1:0] == 2'b01);
        r0e_m[c]  = (inst_w[1:0] == 2'b10);
        r3l_m[c]  = (inst_w[7:6] == 2'b01);
        r3e_m[c]  = (inst_w[7:6] == 2'b10);
      end
    end
    start = 1'b0;
    l0_empty = 1'b0;
    $display("pass K=%0d E=%0d: issues=%0d done_cycle=%0d", k, e, rd_cnt, done_cyc);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_l0_rd", l0_rd, 1'b0);
    check("rst_inst_w", inst_w, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // No-stall pass
    run_pass(4, 3, -1, -1, -1, -1, 24);
    check("p1_rd", rd_m, rng(1, 4) | rng(6, 8));
    check("p1_r0_load", r0l_m, rng(2, 5));
    check("p1_r0_exec", r0e_m, rng(7, 9));
    check("p1_r3_load", r3l_m, rng(5, 8));
    check("p1_r3_exec", r3e_m, rng(10, 12));
    check("p1_busy", busy_m, rng(1, 16));
    check("p1_done", done_m, rng(16, 16));

    // Two-cycle stall in LOAD
    run_pass(4, 3, 2, 3, -1, -1, 26);
    check("p2_rd", rd_m, rng(1, 1) | rng(4, 6) | rng(8, 10));
    check("p2_rd_cnt", rd_cnt, 7);
    check("p2_r0_load", r0l_m, rng(2, 2) | rng(5, 7));
    check("p2_r0_exec", r0e_m, rng(9, 11));
    check("p2_r3_exec", r3e_m, rng(12, 14));
    check("p2_done", done_m, rng(18, 18));

    // K=0, E=2
    run_pass(0, 2, -1, -1, -1, -1, 16);
    check("p3_load_any", load_any_cnt, 0);
    check("p3_rd", rd_m, rng(2, 3));
    check("p3_r0_exec", r0e_m, rng(3, 4));
    check("p3_done", done_m, rng(11, 11));

    // K=0, E=0
    run_pass(0, 0, -1, -1, -1, -1, 14);
    check("p4_rd", rd_m, '0);
    check("p4_busy", busy_m, rng(1, 9));
    check("p4_done", done_m, rng(9, 9));

    // Start pulses during LOAD and DRAIN are ignored
    run_pass(4, 3, -1, -1, 2, 11, 40);
    check("p5_done_cnt", done_cnt, 1);
    check("p5_done", done_m, rng(16, 16));
    check("p5_rd", rd_m, rng(1, 4) | rng(6, 8));

    // Asynchronous reset while in EXEC
    run_pass(4, 3, -1, -1, -1, -1, 8);
    check("p6_pre_rd", l0_rd, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("p6_rst_rd", l0_rd, 1'b0);
    check("p6_rst_inst", inst_w, '0);
    check("p6_rst_busy", busy, 1'b0);
    check("p6_rst_done", done, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("p6_idle_after_rst", done_cnt, 0);
    run_pass(4, 3, -1, -1, -1, -1, 24);
    check("p6_rd", rd_m, rng(1, 4) | rng(6, 8));
    check("p6_r0_exec", r0e_m, rng(7, 9));
    check("p6_done", done_m, rng(16, 16));

    // Maximum kernel count, no wrap
    run_pass(255, 0, -1, -1, -1, -1, 280);
    check("p7_rd_cnt", rd_cnt, 255);
    check("p7_r0_load", r0l_cnt, 255);
    check("p7_r3_load", r3l_cnt, 255);
    check("p7_done_cyc", done_cyc, 264);
    check("p7_done_cnt", done_cnt, 1);

    check("never_11", illegal, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac_row_ctrl.md
MAC_ROW_CTRL -- requirements
Module: mac_row_ctrl

Interface
REQ-001 SHALL have parameter row, default 8: number of mac_row instances sequenced.
REQ-002 SHALL have parameter col, default 8: tiles per mac_row.
REQ-003 SHALL have parameter cnt_bw, default 8: width of cycle-count inputs and internal counter.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: begin one load+execute pass; sampled only in IDLE.
REQ-007 SHALL have port kernel_cycles, input, cnt_bw: number of kernel-load issues (inst 2'b01).
REQ-008 SHALL have port exec_cycles, input, cnt_bw: number of execute issues (inst 2'b10).
REQ-009 SHALL have port l0_empty, input, 1: input buffer has no word; stalls issue.
REQ-010 SHALL have port l0_rd, output, 1: input-buffer read strobe, one word per asserted cycle.
REQ-011 SHALL have port inst_w, output, 2*row: per-row inst_w, row r on bits [2r+1:2r]; bit1 = execute, bit0 = kernel load.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1: single-cycle pulse at the end of a pass.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, GAP, EXEC, DRAIN, DONE.
REQ-015 SHALL transition IDLE->LOAD on start=1; kernel_cycles=0 skips LOAD and goes to GAP; start is ignored outside IDLE.
REQ-016 SHALL, in LOAD/EXEC, issue when l0_empty=0: l0_rd=1, issue_inst = 01 (LOAD) / 10 (EXEC), issue counter +1.
REQ-017 SHALL, in LOAD/EXEC with l0_empty=1, stall: l0_rd=0, issue_inst=00, counter holds, state holds.
REQ-018 SHALL leave LOAD after the kernel_cycles-th issue, enter GAP for exactly 1 cycle (issue_inst=00, l0_rd=0), then EXEC; exec_cycles=0 skips EXEC and goes to DRAIN.
REQ-019 SHALL leave EXEC after the exec_cycles-th issue; the counter clears on every phase entry.
REQ-020 SHALL hold DRAIN for exactly row+col-1 cycles, then DONE for 1 cycle (done=1), then return to IDLE.
REQ-021 SHALL drive l0_rd combinationally from state and l0_empty; it SHALL be 0 in IDLE, GAP, DRAIN and DONE.
REQ-022 SHALL register issue_inst onto inst_w[1:0] one cycle after issue, aligned with l0 read data.
REQ-023 SHALL drive inst_w row r as row 0 delayed by r register stages (shift chain), giving the diagonal wavefront.
REQ-024 SHALL never drive 2'b11 on any inst_w row.
REQ-025 SHALL compare counters at cnt_bw width without wrap; a count of 2^cnt_bw-1 is legal.

Reset
REQ-026 SHALL, on reset=0 at any time including mid-pass, immediately force: state IDLE, counter 0, all inst_w bits 0, busy 0, done 0, l0_rd 0.
REQ-027 SHALL resume in IDLE after reset release and require a fresh start.

Verification (row=4, col=4, cycle 0 = the edge sampling start)
REQ-028 SHALL cover the no-stall pass: K=4, E=3 -> l0_rd=1 in cycles 1-4 and 6-8; row0 inst 01 in cycles 2-5 and 10 in cycles 7-9; row3 inst 01 in cycles 5-8 and 10 in cycles 10-12; DRAIN cycles 9-15; done=1 only in cycle 16; busy=1 in cycles 1-16.
REQ-029 SHALL cover a stall: K=4, E=3, l0_empty=1 in cycles 2-3 -> l0_rd=0 and row0 inst 00 for the corresponding cycles; total issues remain 4 and 3; done is delayed by exactly 2 cycles.
REQ-030 SHALL cover zero counts: K=0, E=2 -> no 01 on any row; K=0, E=0 -> no l0_rd; done=1 after GAP + 7 DRAIN cycles.
REQ-031 SHALL cover reset mid-pass: reset=0 during EXEC -> all outputs 0 asynchronously; no done pulse; the next start runs a full pass correctly.
REQ-032 SHALL cover start while busy: start pulses during LOAD and DRAIN -> ignored; exactly one done pulse is produced.
REQ-033 SHALL cover the maximum count: K=255 -> exactly 255 issues in LOAD with no counter wrap.
